// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
//   master : drives winc/wdata/rinc, observes wfull/rdata/rempty/count
//   slave  : the FIFO itself
interface sync_fifo_if #(
   parameter int unsigned data_bits    = 8,
   parameter int unsigned address_bits = 4
);
   logic                    winc;
   logic [data_bits-1:0]    wdata;
   logic                    wfull;
   logic                    rinc;
   logic [data_bits-1:0]    rdata;
   logic                    rempty;
   logic [address_bits:0]   count;

   modport master (
      output winc, wdata, rinc,
      input  wfull, rdata, rempty, count
   );

   modport slave (
      input  winc, wdata, rinc,
      output wfull, rdata, rempty, count
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO, depth 2**address_bits.
//   wclk   : clock, all state changes on rising edge
//   wrst_n : asynchronous active-low reset (pointers only; array retained)
//   fifo   : slave side of sync_fifo_if
//            winc/wdata push, rinc pop, rdata = oldest word,
//            wfull/rempty flags, count = stored words (0..depth)
module sync_fifo #(
   parameter int unsigned data_bits    = 8,
   parameter int unsigned address_bits = 4
) (
   input  logic          wclk,
   input  logic          wrst_n,
   sync_fifo_if.slave    fifo
);
   localparam int unsigned ptr_bits = address_bits + 1;
   localparam int unsigned depth    = 1 << address_bits;

   logic [data_bits-1:0] mem [depth];
   logic [ptr_bits-1:0]  wptr;
   logic [ptr_bits-1:0]  rptr;
   logic                 full_c;
   logic                 empty_c;
   logic                 wr_en_c;
   logic                 rd_en_c;

   // Flags from registered pointers; the MSB disambiguates full vs empty.
   assign empty_c = (wptr == rptr);
   assign full_c  = (wptr[address_bits] != rptr[address_bits]) &&
                    (wptr[address_bits-1:0] == rptr[address_bits-1:0]);

   // Requests against full/empty are dropped.
   assign wr_en_c = fifo.winc & ~full_c;
   assign rd_en_c = fifo.rinc & ~empty_c;

   // Storage array, intentionally not reset.
   always_ff @(posedge wclk) begin
      if (wr_en_c) begin
         mem[wptr[address_bits-1:0]] <= fifo.wdata;
      end
   end

   // Binary pointers with wrap bit.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en_c) wptr <= wptr + ptr_bits'(1);
         if (rd_en_c) rptr <= rptr + ptr_bits'(1);
      end
   end

   assign fifo.wfull  = full_c;
   assign fifo.rempty = empty_c;
   assign fifo.count  = wptr - rptr;
   assign fifo.rdata  = mem[rptr[address_bits-1:0]];
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue reference model.
module tb_sync_fifo;
   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 1 << AW;

   logic wclk;
   logic wrst_n;
   int   checks;
   int   errors;
   logic [DW-1:0] model [$];

   sync_fifo_if #(.data_bits(DW), .address_bits(AW)) bus ();

   sync_fifo #(.data_bits(DW), .address_bits(AW)) dut (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .fifo   (bus)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   // One clock of stimulus; model applies the FIFO rules using pre-edge occupancy.
   task automatic tick(input logic w, input logic r, input logic [DW-1:0] d);
      bit do_w;
      bit do_r;
      logic [DW-1:0] tmp;
      bus.winc  = w;
      bus.rinc  = r;
      bus.wdata = d;
      do_w = w && (model.size() < DEPTH);
      do_r = r && (model.size() != 0);
      @(posedge wclk);
      if (do_r) tmp = model.pop_front();
      if (do_w) model.push_back(d);
      #1;
      bus.winc = 1'b0;
      bus.rinc = 1'b0;
   endtask

   task automatic test_reset();
      // Power-up reset, checked before any clock edge matters.
      wrst_n = 1'b0;
      bus.winc = 1'b0; bus.rinc = 1'b0; bus.wdata = '0;
      #3;
      checks++; if (bus.rempty !== 1'b1) begin errors++; $display("FAIL por_rempty got %b exp 1", bus.rempty); end
      checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL por_wfull got %b exp 0", bus.wfull); end
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL por_count got %0d exp 0", bus.count); end
      @(negedge wclk);
      wrst_n = 1'b1;
      @(posedge wclk); #1;
      // Mid-stream reset with 5 words stored.
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, DW'(8'h10 + i));
      checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL pre_rst_count got %0d exp 5", bus.count); end
      wrst_n = 1'b0;
      #1;
      model.delete();
      checks++; if (bus.rempty !== 1'b1) begin errors++; $display("FAIL async_rst_rempty got %b exp 1", bus.rempty); end
      checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL async_rst_wfull got %b exp 0", bus.wfull); end
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL async_rst_count got %0d exp 0", bus.count); end
      @(negedge wclk);
      wrst_n = 1'b1;
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, '0);
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL rst_pop_count got %0d exp 0", bus.count); end
      checks++; if (bus.rempty !== 1'b1) begin errors++; $display("FAIL rst_pop_rempty got %b exp 1", bus.rempty); end
   endtask

   task automatic test_basic();
      tick(1'b1, 1'b0, 8'hFF);
      tick(1'b1, 1'b0, 8'h3F);
      checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL basic_count2 got %0d exp 2", bus.count); end
      checks++; if (bus.rdata !== 8'hFF) begin errors++; $display("FAIL basic_head got %h exp ff", bus.rdata); end
      tick(1'b0, 1'b1, '0);
      checks++; if (bus.rdata !== 8'h3F) begin errors++; $display("FAIL basic_pop got %h exp 3f", bus.rdata); end
      checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL basic_count1 got %0d exp 1", bus.count); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 15; i++) tick(1'b1, 1'b0, 8'hFF);
      checks++; if (bus.wfull !== 1'b1) begin errors++; $display("FAIL fill_wfull got %b exp 1", bus.wfull); end
      checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", bus.count); end
      tick(1'b1, 1'b0, 8'hE7);
      checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL overflow_count got %0d exp 16", bus.count); end
      checks++; if (bus.wfull !== 1'b1) begin errors++; $display("FAIL overflow_wfull got %b exp 1", bus.wfull); end
   endtask

   task automatic test_drain_wrap();
      logic [DW-1:0] seq [3];
      seq[0] = 8'hFF; seq[1] = 8'hE7; seq[2] = 8'hFC;
      for (int i = 0; i < 16; i++) begin
         checks++; if (bus.rdata !== model[0]) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, bus.rdata, model[0]); end
         tick(1'b0, 1'b1, '0);
      end
      checks++; if (bus.rempty !== 1'b1) begin errors++; $display("FAIL drain_rempty got %b exp 1", bus.rempty); end
      tick(1'b0, 1'b1, '0);
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL underflow_count got %0d exp 0", bus.count); end
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, seq[i]);
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.rdata !== seq[i]) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, bus.rdata, seq[i]); end
         tick(1'b0, 1'b1, '0);
      end
      checks++; if (bus.rempty !== 1'b1) begin errors++; $display("FAIL wrap_rempty got %b exp 1", bus.rempty); end
   endtask

   task automatic test_simultaneous();
      logic [DW-1:0] d;
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, DW'($urandom));
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 1'b1, DW'($urandom));
         checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL simul_count[%0d] got %0d exp 5", i, bus.count); end
         checks++; if (bus.rdata !== model[0]) begin errors++; $display("FAIL simul_data[%0d] got %h exp %h", i, bus.rdata, model[0]); end
      end
      while (model.size() < DEPTH) tick(1'b1, 1'b0, DW'($urandom));
      tick(1'b1, 1'b1, 8'hA5);
      checks++; if (bus.count !== 5'd15) begin errors++; $display("FAIL simul_full_count got %0d exp 15", bus.count); end
      checks++; if (bus.rdata !== model[0]) begin errors++; $display("FAIL simul_full_data got %h exp %h", bus.rdata, model[0]); end
      while (model.size() != 0) tick(1'b0, 1'b1, '0);
      d = 8'h5A;
      tick(1'b1, 1'b1, d);
      checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL simul_empty_count got %0d exp 1", bus.count); end
      checks++; if (bus.rdata !== d) begin errors++; $display("FAIL simul_empty_data got %h exp %h", bus.rdata, d); end
      tick(1'b0, 1'b1, '0);
   endtask

   task automatic test_random();
      int unsigned pw;
      int unsigned pr;
      for (int i = 0; i < 10000; i++) begin
         case ((i / 1000) % 3)
            0: begin pw = 80; pr = 30; end
            1: begin pw = 30; pr = 80; end
            default: begin pw = 55; pr = 55; end
         endcase
         tick(($urandom_range(99) < pw), ($urandom_range(99) < pr), DW'($urandom));
         checks++; if (bus.count !== 5'(model.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d exp %0d", i, bus.count, model.size()); end
         checks++; if (bus.rempty !== (model.size() == 0)) begin errors++; $display("FAIL rand_rempty[%0d] got %b exp %b", i, bus.rempty, model.size() == 0); end
         checks++; if (bus.wfull !== (model.size() == DEPTH)) begin errors++; $display("FAIL rand_wfull[%0d] got %b exp %b", i, bus.wfull, model.size() == DEPTH); end
         if (model.size() != 0) begin
            checks++; if (bus.rdata !== model[0]) begin errors++; $display("FAIL rand_rdata[%0d] got %h exp %h", i, bus.rdata, model[0]); end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_fill();
      test_drain_wrap();
      test_simultaneous();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
      $fatal(1);
   end
endmodule
